// File: rtl/line_clear_ctrl_if.sv
// Row-organised grid memory port between line_clear_ctrl (master) and the grid storage (slave).
// Handshake: row_rd_en/row_wr_en are single-cycle valid strobes with no ready. The storage must
// accept each strobe in the cycle it is high. row_rdata returns the addressed row one cycle after row_rd_en.
interface line_clear_ctrl_if #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int CW   = 3
);
    localparam int RW = $clog2(ROWS);
    localparam int DW = COLS * CW;

    logic          row_rd_en;
    logic [RW-1:0] row_raddr;
    logic [DW-1:0] row_rdata;
    logic          row_wr_en;
    logic [RW-1:0] row_waddr;
    logic [DW-1:0] row_wdata;

    modport master (
        output row_rd_en, row_raddr, row_wr_en, row_waddr, row_wdata,
        input  row_rdata
    );

    modport slave (
        input  row_rd_en, row_raddr, row_wr_en, row_waddr, row_wdata,
        output row_rdata
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, compacts survivors downward, zero-fills the top.
// Optional score accumulator is built only when LINE_CLEAR_SCORE_EN is defined.
module line_clear_ctrl #(
    parameter int  ROWS = 20,
    parameter int  COLS = 10,
    parameter int  CW   = 3,
    localparam int RW   = $clog2(ROWS),
    localparam int LW   = $clog2(ROWS + 1),
    localparam int DW   = COLS * CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] lines,
    output logic [19:0]   score,
    output logic [2:0]    dbg_state,
    line_clear_ctrl_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EVAL = 3'd2,
        S_FILL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [RW-1:0] rd_ptr, rd_ptr_d;
    logic [RW-1:0] wr_ptr, wr_ptr_d;
    logic [LW-1:0] cnt, cnt_d;
    logic          row_full;

    assign dbg_state = state;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (mem.row_rdata[c*CW +: CW] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state;
        rd_ptr_d = rd_ptr;
        wr_ptr_d = wr_ptr;
        cnt_d    = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RD;
                    rd_ptr_d = RW'(ROWS - 1);
                    wr_ptr_d = RW'(ROWS - 1);
                    cnt_d    = '0;
                end
            end
            S_RD: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (row_full) begin
                    cnt_d = cnt + LW'(1);
                end else begin
                    wr_ptr_d = wr_ptr - RW'(1);
                end
                if (rd_ptr == '0) begin
                    state_d = (cnt_d != '0) ? S_FILL : S_DONE;
                end else begin
                    rd_ptr_d = rd_ptr - RW'(1);
                    state_d  = S_RD;
                end
            end
            S_FILL: begin
                // After compaction wr_ptr sits at cnt-1, so the fill ends on row 0.
                if (wr_ptr == '0) begin
                    state_d = S_DONE;
                end else begin
                    wr_ptr_d = wr_ptr - RW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The row under evaluation only arrives in EVAL, so the write port is decoded from the current state.
    always_comb begin
        mem.row_wr_en = 1'b0;
        mem.row_waddr = '0;
        mem.row_wdata = '0;
        if (state == S_EVAL && !row_full && wr_ptr != rd_ptr) begin
            mem.row_wr_en = 1'b1;
            mem.row_waddr = wr_ptr;
            mem.row_wdata = mem.row_rdata;
        end else if (state == S_FILL) begin
            mem.row_wr_en = 1'b1;
            mem.row_waddr = wr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines         <= '0;
            mem.row_rd_en <= 1'b0;
            mem.row_raddr <= '0;
        end else begin
            state         <= state_d;
            rd_ptr        <= rd_ptr_d;
            wr_ptr        <= wr_ptr_d;
            cnt           <= cnt_d;
            busy          <= (state_d != S_IDLE);
            done          <= (state_d == S_DONE);
            mem.row_rd_en <= (state_d == S_RD);
            if (state_d == S_RD) begin
                mem.row_raddr <= rd_ptr_d;
            end
            if (state_d == S_DONE) begin
                lines <= cnt_d;
            end
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0] score_add;
    logic [20:0] score_sum;

    always_comb begin
        case (cnt_d)
            LW'(0):  score_add = 11'd0;
            LW'(1):  score_add = 11'd40;
            LW'(2):  score_add = 11'd100;
            LW'(3):  score_add = 11'd300;
            default: score_add = 11'd1200;
        endcase
        score_sum = {1'b0, score} + {10'd0, score_add};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (state_d == S_DONE) begin
            score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: random grids, behavioural grid model, score model.
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int RW   = $clog2(ROWS);
  localparam int LW   = $clog2(ROWS + 1);
  localparam int DW   = COLS * CW;
  localparam int SMAX = 1048575;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [LW-1:0] lines;
  logic [19:0]   score;
  logic [2:0]    dbg_state;

  line_clear_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) mif ();

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .lines     (lines),
    .score     (score),
    .dbg_state (dbg_state),
    .mem       (mif.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  // grid storage model and activity counters
  logic [DW-1:0] mem [ROWS];
  logic [DW-1:0] grid_init [ROWS];
  bit            load_req = 1'b0;
  int            rd_cnt = 0, wr_cnt = 0, hz_cnt = 0, done_cnt = 0, last_raddr = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= grid_init[r];
    end else if (mif.row_wr_en) begin
      mem[mif.row_waddr] <= mif.row_wdata;
      wr_cnt <= wr_cnt + 1;
      if (int'(mif.row_waddr) < last_raddr) hz_cnt <= hz_cnt + 1;
    end
    if (mif.row_rd_en) begin
      mif.row_rdata <= mem[mif.row_raddr];
      rd_cnt <= rd_cnt + 1;
      last_raddr <= int'(mif.row_raddr);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // scoreboard
  logic [DW-1:0] exp_q [$];
  int exp_lines, exp_writes, exp_score;
  int n_cmp = 0, n_err = 0;

  function automatic bit row_is_full(input logic [DW-1:0] row);
    for (int c = 0; c < COLS; c++) if (row[c*CW +: CW] == '0) return 1'b0;
    return 1'b1;
  endfunction

  // survivors keep their bottom-up order and pack against the floor; cleared rows reappear as zeros on top
  task automatic model_pass();
    logic [DW-1:0] surv [$];
    int old_idx [$];
    int nf, add;
    nf = 0;
    exp_q.delete();
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_is_full(grid_init[r])) nf++;
      else begin
        surv.push_back(grid_init[r]);
        old_idx.push_back(r);
      end
    end
    exp_writes = nf;
    for (int i = 0; i < surv.size(); i++) if (old_idx[i] != ROWS - 1 - i) exp_writes++;
    for (int r = 0; r < ROWS; r++) begin
      if (r < nf) exp_q.push_back('0);
      else exp_q.push_back(surv[ROWS - 1 - r]);
    end
    exp_lines = nf;
`ifdef LINE_CLEAR_SCORE_EN
    add = (nf == 0) ? 0 : (nf == 1) ? 40 : (nf == 2) ? 100 : (nf == 3) ? 300 : 1200;
    exp_score = (exp_score + add > SMAX) ? SMAX : exp_score + add;
`else
    add = 0;
    exp_score = add;
`endif
  endtask

  // driver tasks
  task automatic make_grid(input logic [ROWS-1:0] mask, input bit empty);
    logic [DW-1:0] v;
    int k;
    for (int r = 0; r < ROWS; r++) begin
      v = '0;
      if (!empty) begin
        for (int c = 0; c < COLS; c++)
          v[c*CW +: CW] = mask[r] ? CW'($urandom_range(1, 7)) : CW'($urandom_range(0, 7));
        if (!mask[r]) begin
          k = $urandom_range(0, COLS - 1);
          v[k*CW +: CW] = '0;
        end
      end
      grid_init[r] = v;
    end
  endtask

  task automatic load_grid();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic run_pass(input int restart_at, input bit settle, output int lat, output bit tmo,
                          output int pulses, output int reads, output int writes, output int hz);
    int d0, r0, w0, h0;
    @(posedge clk); #1;
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt; h0 = hz_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    tmo = 1'b1;
    while (lat < 4 * ROWS + 10) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == restart_at);
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
    if (settle) repeat (3 * ROWS + 5) @(posedge clk);
    else @(posedge clk);
    #1;
    pulses = done_cnt - d0;
    reads  = rd_cnt - r0;
    writes = wr_cnt - w0;
    hz     = hz_cnt - h0;
  endtask

  // tests
  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (lines !== '0) begin n_err++; $display("FAIL reset_lines got=%0d exp=0", lines); end
    n_cmp++; if (score !== '0) begin n_err++; $display("FAIL reset_score got=%0d exp=0", score); end
    n_cmp++; if (mif.row_rd_en !== 1'b0 || mif.row_raddr !== '0)
      begin n_err++; $display("FAIL reset_rd got en=%b addr=%0d exp 0/0", mif.row_rd_en, mif.row_raddr); end
    n_cmp++; if (mif.row_wr_en !== 1'b0 || mif.row_waddr !== '0 || mif.row_wdata !== '0)
      begin n_err++; $display("FAIL reset_wr got en=%b addr=%0d data=%h exp zeros", mif.row_wr_en, mif.row_waddr, mif.row_wdata); end
    @(negedge clk) rst_n = 1'b1;
    exp_score = 0;
  endtask

  task automatic test_clear_pattern(input string name, input logic [ROWS-1:0] mask, input bit empty, input int restart_at);
    int lat, pulses, reads, writes, hz;
    bit tmo;
    logic [DW-1:0] e;
    make_grid(mask, empty);
    load_grid();
    model_pass();
    run_pass(restart_at, 1'b1, lat, tmo, pulses, reads, writes, hz);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL %s_timeout no done within %0d cycles", name, lat); end
    n_cmp++; if (lat !== 2 * ROWS + exp_lines) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, 2 * ROWS + exp_lines); end
    n_cmp++; if (lines !== LW'(exp_lines)) begin n_err++; $display("FAIL %s_lines got=%0d exp=%0d", name, lines, exp_lines); end
    n_cmp++; if (score !== 20'(exp_score)) begin n_err++; $display("FAIL %s_score got=%0d exp=%0d", name, score, exp_score); end
    n_cmp++; if (reads !== ROWS) begin n_err++; $display("FAIL %s_reads got=%0d exp=%0d", name, reads, ROWS); end
    n_cmp++; if (writes !== exp_writes) begin n_err++; $display("FAIL %s_writes got=%0d exp=%0d", name, writes, exp_writes); end
    n_cmp++; if (hz !== 0) begin n_err++; $display("FAIL %s_hazard got=%0d writes below read row exp=0", name, hz); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL %s_done_pulses got=%0d exp=1", name, pulses); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after got=%b exp=0", name, busy); end
    for (int r = 0; r < ROWS; r++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (mem[r] !== e) begin n_err++; $display("FAIL %s_row%0d got=%h exp=%h", name, r, mem[r], e); end
    end
  endtask

  task automatic test_directed();
    logic [ROWS-1:0] m;
    m = '0;        test_clear_pattern("empty", m, 1'b1, -1);
    m = '0; m[19] = 1'b1; test_clear_pattern("one_row", m, 1'b0, -1);
    m[17] = 1'b1;  test_clear_pattern("two_rows", m, 1'b0, -1);
    m = '0; for (int r = 16; r < 20; r++) m[r] = 1'b1;
    test_clear_pattern("four_rows", m, 1'b0, -1);
    m = '1;        test_clear_pattern("all_full", m, 1'b0, -1);
    m = '0; m[0] = 1'b1; test_clear_pattern("top_row", m, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [ROWS-1:0] m;
    repeat (6) begin
      for (int r = 0; r < ROWS; r++) m[r] = ($urandom_range(0, 2) == 0);
      test_clear_pattern("random", m, 1'b0, -1);
    end
  endtask

  task automatic test_start_ignored();
    logic [ROWS-1:0] m;
    m = '0; m[18] = 1'b1; m[5] = 1'b1;
    test_clear_pattern("start_busy", m, 1'b0, 5);
  endtask

  task automatic test_reset_mid_pass();
    logic [ROWS-1:0] m;
    m = '0; m[19] = 1'b1; m[10] = 1'b1;
    make_grid(m, 1'b0);
    load_grid();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_ctl got busy=%b done=%b exp 0/0", busy, done); end
    n_cmp++; if (lines !== '0 || score !== '0) begin n_err++; $display("FAIL midrst_out got lines=%0d score=%0d exp 0/0", lines, score); end
    n_cmp++; if (mif.row_rd_en !== 1'b0 || mif.row_raddr !== '0)
      begin n_err++; $display("FAIL midrst_rd got en=%b addr=%0d exp 0/0", mif.row_rd_en, mif.row_raddr); end
    n_cmp++; if (mif.row_wr_en !== 1'b0 || mif.row_waddr !== '0 || mif.row_wdata !== '0)
      begin n_err++; $display("FAIL midrst_wr got en=%b addr=%0d data=%h exp zeros", mif.row_wr_en, mif.row_waddr, mif.row_wdata); end
    exp_score = 0;
    @(negedge clk) rst_n = 1'b1;
    test_clear_pattern("post_reset", m, 1'b0, -1);
  endtask

`ifdef LINE_CLEAR_SCORE_EN
  task automatic test_score_saturation();
    logic [ROWS-1:0] m;
    int lat, pulses, reads, writes, hz, guard, tmo_cnt;
    bit tmo;
    m = '1;
    guard = 0;
    tmo_cnt = 0;
    while (exp_score < SMAX && guard < 1000) begin
      make_grid(m, 1'b0);
      load_grid();
      model_pass();
      run_pass(-1, 1'b0, lat, tmo, pulses, reads, writes, hz);
      if (tmo) tmo_cnt++;
      guard++;
    end
    n_cmp++; if (tmo_cnt !== 0) begin n_err++; $display("FAIL sat_timeouts got=%0d exp=0", tmo_cnt); end
    n_cmp++; if (score !== 20'(exp_score)) begin n_err++; $display("FAIL sat_score got=%0d exp=%0d", score, exp_score); end
    make_grid(m, 1'b0);
    test_clear_pattern("sat_hold", m, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_pass();
`ifdef LINE_CLEAR_SCORE_EN
    test_score_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
